// File: rtl/val2_shift_sequencer.sv
// Multi-cycle Val2 shifter for register-specified shift amounts.
// Shifts the latched operand by up to STEP bits per cycle and tracks the shifter carry-out.
module val2_shift_sequencer #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [1:0]  shift_type,
    input  logic [31:0] val_rm,
    input  logic [31:0] val_rs,
    input  logic        c_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] Val2,
    output logic        c_out,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;
    localparam logic [5:0] STEP_W = 6'(STEP);

    // Handshake: start is accepted only when busy=0 (IDLE or DONE) and flush=0;
    // done is a single-cycle pulse with Val2/c_out already valid in that cycle.

    state_t      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [1:0]  type_q, type_d;
    logic        carry_q, carry_d;
    logic [5:0]  rem_q, rem_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] val2_q, val2_d;
    logic        c_out_q, c_out_d;

    logic [7:0]  amt;
    logic [5:0]  n_eff;
    logic [5:0]  k;
    logic [5:0]  rem_next;
    logic [31:0] step_res;
    logic        step_c;
    logic        accept;
    logic        unused_rs;

    assign amt       = val_rs[7:0];
    assign unused_rs = ^val_rs[31:8];
    assign accept    = start && !flush && (state_q == IDLE || state_q == DONE);

    // Effective count saturates where further shifting can no longer change result or carry.
    always_comb begin
        n_eff = 6'd0;
        case (shift_type)
            T_LSL, T_LSR: n_eff = (amt > 8'd33) ? 6'd33 : amt[5:0];
            T_ASR:        n_eff = (amt > 8'd32) ? 6'd32 : amt[5:0];
            default: begin
                if (amt == 8'd0)
                    n_eff = 6'd0;
                else if (amt[4:0] == 5'd0)
                    n_eff = 6'd32;
                else
                    n_eff = {1'b0, amt[4:0]};
            end
        endcase
    end

    always_comb begin
        k        = (rem_q < STEP_W) ? rem_q : STEP_W;
        rem_next = rem_q - k;
        step_res = work_q;
        step_c   = carry_q;
        case (type_q)
            T_LSL: begin
                step_res = work_q << k;
                step_c   = work_q[5'(6'd32 - k)];
            end
            T_LSR: begin
                step_res = work_q >> k;
                step_c   = work_q[5'(k - 6'd1)];
            end
            T_ASR: begin
                step_res = 32'($signed(work_q) >>> k);
                step_c   = work_q[5'(k - 6'd1)];
            end
            default: begin
                step_res = (work_q >> k) | (work_q << (6'd32 - k));
                step_c   = work_q[5'(k - 6'd1)];
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        type_d  = type_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        val2_d  = val2_q;
        c_out_d = c_out_q;

        if (flush) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else if (accept) begin
            work_d  = val_rm;
            type_d  = shift_type;
            carry_d = c_in;
            rem_d   = n_eff;
            if (n_eff == 6'd0) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                val2_d  = val_rm;
                c_out_d = c_in;
            end else begin
                state_d = SHIFT;
                busy_d  = 1'b1;
            end
        end else begin
            case (state_q)
                SHIFT: begin
                    work_d  = step_res;
                    carry_d = step_c;
                    rem_d   = rem_next;
                    if (rem_next == 6'd0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        val2_d  = step_res;
                        c_out_d = step_c;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            work_q  <= 32'd0;
            type_q  <= 2'd0;
            carry_q <= 1'b0;
            rem_q   <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            val2_q  <= 32'd0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            type_q  <= type_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            val2_q  <= val2_d;
            c_out_q <= c_out_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign Val2    = val2_q;
    assign c_out   = c_out_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// Directed-vector bench for val2_shift_sequencer (STEP=4): shift semantics, latency and control events.
module tb_val2_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  shift_type = 2'd0;
    logic [31:0] val_rm = 32'd0;
    logic [31:0] val_rs = 32'd0;
    logic        c_in = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] Val2;
    logic        c_out;
    logic [1:0]  state_o;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    val2_shift_sequencer #(.STEP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .shift_type(shift_type), .val_rm(val_rm), .val_rs(val_rs), .c_in(c_in),
        .busy(busy), .done(done), .Val2(Val2), .c_out(c_out), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  t;
        logic [31:0] rm;
        logic [31:0] rs;
        logic        ci;
        logic [31:0] ev;
        logic        ec;
        int          el;
    } vec_t;

    vec_t vecs[15];

    // Issues one operation and returns done latency in cycles after the start cycle (-1 on timeout).
    task automatic do_op(input logic [1:0] t, input logic [31:0] rm, input logic [31:0] rs,
                         input logic ci, output int lat, output int bcnt);
        @(negedge clk);
        shift_type = t; val_rm = rm; val_rs = rs; c_in = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        bcnt = 0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            if (done) lat = c;
            else if (busy) bcnt++;
            if (lat < 0) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || Val2 !== 32'd0 || c_out !== 1'b0 || state_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset: busy=%b done=%b val2=%h c=%b st=%0d required 0 0 0 0 0",
                     busy, done, Val2, c_out, state_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || state_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_release: busy=%b done=%b st=%0d required idle", busy, done, state_o);
        end
    endtask

    task automatic test_shift_types();
        int lat;
        int bcnt;
        vecs[0]  = '{LSL, 32'h0000_0001, 32'd4,        1'b0, 32'h0000_0010, 1'b0, 2};
        vecs[1]  = '{LSR, 32'h8000_0000, 32'd32,       1'b0, 32'h0000_0000, 1'b1, 9};
        vecs[2]  = '{LSL, 32'hFFFF_FFFF, 32'd40,       1'b0, 32'h0000_0000, 1'b0, 10};
        vecs[3]  = '{ASR, 32'h8000_0000, 32'h28,       1'b0, 32'hFFFF_FFFF, 1'b1, 9};
        vecs[4]  = '{ROR, 32'h0000_0001, 32'h21,       1'b0, 32'h8000_0000, 1'b1, 2};
        vecs[5]  = '{ROR, 32'h0000_0001, 32'h20,       1'b0, 32'h0000_0001, 1'b0, 9};
        vecs[6]  = '{ROR, 32'h0000_0001, 32'h100,      1'b1, 32'h0000_0001, 1'b1, 1};
        vecs[7]  = '{LSR, 32'h0000_00F0, 32'd5,        1'b0, 32'h0000_0007, 1'b1, 3};
        vecs[8]  = '{ASR, 32'h8000_0010, 32'd5,        1'b0, 32'hFC00_0000, 1'b1, 3};
        vecs[9]  = '{LSL, 32'h8000_0001, 32'd33,       1'b1, 32'h0000_0000, 1'b0, 10};
        vecs[10] = '{LSL, 32'h0000_0001, 32'd32,       1'b0, 32'h0000_0000, 1'b1, 9};
        vecs[11] = '{ASR, 32'h7FFF_FFFF, 32'hFF,       1'b1, 32'h0000_0000, 1'b0, 9};
        vecs[12] = '{LSR, 32'h1234_5678, 32'd0,        1'b0, 32'h1234_5678, 1'b0, 1};
        vecs[13] = '{ROR, 32'h0000_000F, 32'd4,        1'b0, 32'hF000_0000, 1'b1, 2};
        vecs[14] = '{LSL, 32'h0000_0001, 32'hFFFF_FF03, 1'b1, 32'h0000_0008, 1'b0, 2};
        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].t, vecs[i].rm, vecs[i].rs, vecs[i].ci, lat, bcnt);
            tests_run++;
            if (lat !== vecs[i].el) begin
                tests_failed++;
                $display("FAIL vec%0d latency: got %0d required %0d", i, lat, vecs[i].el);
            end
            tests_run++;
            if (Val2 !== vecs[i].ev) begin
                tests_failed++;
                $display("FAIL vec%0d val2: got %h required %h", i, Val2, vecs[i].ev);
            end
            tests_run++;
            if (c_out !== vecs[i].ec) begin
                tests_failed++;
                $display("FAIL vec%0d c_out: got %b required %b", i, c_out, vecs[i].ec);
            end
            tests_run++;
            if (bcnt !== vecs[i].el - 1) begin
                tests_failed++;
                $display("FAIL vec%0d busy_cycles: got %0d required %0d", i, bcnt, vecs[i].el - 1);
            end
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0 || state_o !== 2'd0) begin
                tests_failed++;
                $display("FAIL vec%0d done_pulse: done=%b st=%0d required 0 0", i, done, state_o);
            end
        end
    endtask

    task automatic test_ignored_start();
        int lat;
        @(negedge clk);
        shift_type = LSR; val_rm = 32'h8000_0000; val_rs = 32'd32; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            if (done) lat = c;
            start = (c == 3);
            if (c == 3) begin
                shift_type = LSL; val_rm = 32'h0000_0001; val_rs = 32'd0; c_in = 1'b1;
            end
            if (lat < 0) @(negedge clk);
        end
        start = 1'b0;
        tests_run++;
        if (lat !== 9 || Val2 !== 32'd0 || c_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignored_start: lat=%0d val2=%h c=%b required 9 00000000 1", lat, Val2, c_out);
        end
    endtask

    task automatic test_flush();
        int lat;
        int bcnt;
        logic saw_done;
        do_op(ROR, 32'h0000_0001, 32'h21, 1'b0, lat, bcnt);
        @(negedge clk);
        shift_type = LSR; val_rm = 32'h8000_0000; val_rs = 32'd32; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw_done = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (done) saw_done = 1'b1;
            flush = (c == 4);
            if (c == 5) begin
                tests_run++;
                if (busy !== 1'b0 || state_o !== 2'd0) begin
                    tests_failed++;
                    $display("FAIL flush_idle: busy=%b st=%0d required 0 0", busy, state_o);
                end
            end
            @(negedge clk);
        end
        flush = 1'b0;
        tests_run++;
        if (saw_done !== 1'b0 || Val2 !== 32'h8000_0000 || c_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_hold: done_seen=%b val2=%h c=%b required 0 80000000 1",
                     saw_done, Val2, c_out);
        end
        // start coinciding with flush in IDLE is dropped
        shift_type = LSL; val_rm = 32'h0000_0003; val_rs = 32'd0; c_in = 1'b0;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        saw_done = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (done || busy || state_o != 2'd0) saw_done = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (saw_done !== 1'b0 || Val2 !== 32'h8000_0000) begin
            tests_failed++;
            $display("FAIL flush_start_drop: activity=%b val2=%h required 0 80000000", saw_done, Val2);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        int bcnt;
        do_op(ROR, 32'h0000_0001, 32'h21, 1'b0, lat, bcnt);
        @(negedge clk);
        shift_type = LSR; val_rm = 32'h8000_0000; val_rs = 32'd32; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_busy: got %b required 1", busy);
        end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || Val2 !== 32'd0 || c_out !== 1'b0 || state_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL async_reset: busy=%b done=%b val2=%h c=%b st=%0d required 0 0 0 0 0",
                     busy, done, Val2, c_out, state_o);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || state_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: busy=%b done=%b st=%0d required idle", busy, done, state_o);
        end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        @(negedge clk);
        shift_type = LSL; val_rm = 32'h0000_0001; val_rs = 32'd4; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat1 = -1;
        for (int c = 1; c <= 20 && lat1 < 0; c++) begin
            if (done) lat1 = c;
            if (lat1 < 0) @(negedge clk);
        end
        tests_run++;
        if (lat1 !== 2 || Val2 !== 32'h0000_0010) begin
            tests_failed++;
            $display("FAIL b2b_first: lat=%0d val2=%h required 2 00000010", lat1, Val2);
        end
        shift_type = LSR; val_rm = 32'h8000_0008; val_rs = 32'd4; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat2 = -1;
        for (int c = 1; c <= 20 && lat2 < 0; c++) begin
            if (done) lat2 = c;
            if (lat2 < 0) @(negedge clk);
        end
        tests_run++;
        if (lat2 !== 2 || Val2 !== 32'h0800_0000 || c_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second: lat=%0d val2=%h c=%b required 2 08000000 1", lat2, Val2, c_out);
        end
    endtask

    initial begin
        test_reset();
        test_shift_types();
        test_ignored_start();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
